// File: rtl/mem_access_ctrl.sv
// Data-side memory sequencer for the multicycle CPU: word/half/byte loads and stores,
// with sub-word stores performed as read-modify-write on the shared byte-addressed memory.
module mem_access_ctrl #(
  parameter int unsigned MEM_LAT     = 1,
  parameter bit          SIGNED_LOAD = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] OP_LW = 3'b000;
  localparam logic [2:0] OP_LH = 3'b001;
  localparam logic [2:0] OP_LB = 3'b010;
  localparam logic [2:0] OP_SW = 3'b100;
  localparam logic [2:0] OP_SH = 3'b101;
  localparam logic [2:0] OP_SB = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    ERR
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] half_q, half_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        reqBad;
  logic [7:0]  rdByte;
  logic [15:0] rdHalf;
  logic [31:0] loadVal;
  logic [31:0] mergeVal;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      op_q        <= 3'd0;
      lane_q      <= 2'd0;
      half_q      <= 16'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      half_q      <= half_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Requests that can never touch memory: illegal opcodes and misaligned word/half accesses.
  always_comb begin
    reqBad = 1'b0;
    case (op)
      OP_LW, OP_SW: reqBad = (addr[1:0] != 2'b00);
      OP_LH, OP_SH: reqBad = addr[0];
      OP_LB, OP_SB: reqBad = 1'b0;
      default:      reqBad = 1'b1;
    endcase
  end

  always_comb begin
    rdByte = mem_rdata[{lane_q, 3'b000} +: 8];
    rdHalf = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    case (op_q)
      OP_LH:   loadVal = {{16{SIGNED_LOAD & rdHalf[15]}}, rdHalf};
      OP_LB:   loadVal = {{24{SIGNED_LOAD & rdByte[7]}}, rdByte};
      default: loadVal = mem_rdata;
    endcase
    mergeVal = mem_rdata;
    if (op_q == OP_SH) begin
      mergeVal[{lane_q[1], 4'b0000} +: 16] = half_q;
    end else begin
      mergeVal[{lane_q, 3'b000} +: 8] = half_q[7:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    lane_d      = lane_q;
    half_d      = half_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    mem_wr      = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    busy        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = op;
          lane_d     = addr[1:0];
          half_d     = wdata[15:0];
          mem_addr_d = {addr[31:2], 2'b00};
          if (reqBad) begin
            state_d = ERR;
          end else if (op == OP_SW) begin
            state_d     = WRITE;
            mem_wdata_d = wdata;
          end else begin
            state_d = READ;
            cnt_d   = 3'(MEM_LAT);
          end
        end
      end
      // The counter runs MEM_LAT down to zero, so READ lasts MEM_LAT+1 cycles.
      READ: begin
        if (cnt_q == 3'd0) begin
          if (!op_q[2]) begin
            rdata_d = loadVal;
            state_d = DONE;
          end else begin
            mem_wdata_d = mergeVal;
            state_d     = WRITE;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      WRITE: begin
        mem_wr  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two configurations (MEM_LAT=1 unsigned, MEM_LAT=3 signed), each with
// its own memory, a transaction-level reference model checked every cycle, and directed literal cases.
module tb_mem_access_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit finishedCfg [2];

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int L = (g == 0) ? 1 : 3;
    localparam bit S = (g == 0) ? 1'b0 : 1'b1;

    logic        reset, start, memWr, busy, done, err;
    logic [2:0]  op;
    logic [31:0] addr, wdata, memRdata, memAddr, memWdata, rdata;
    logic [31:0] physMem [64];
    logic [31:0] refMem [64];
    logic [31:0] pipe [8];
    logic        pokeEn;
    logic [5:0]  pokeIdx;
    logic [31:0] pokeVal;

    bit          mActive, mErr, mLoad, mStore;
    int          mK, mD;
    logic [5:0]  mIdx;
    logic [31:0] mMemAddr, mRdata, mLoadVal, mWrVal;

    mem_access_ctrl #(.MEM_LAT(L), .SIGNED_LOAD(S)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
      .mem_rdata(memRdata), .mem_addr(memAddr), .mem_wr(memWr), .mem_wdata(memWdata),
      .rdata(rdata), .busy(busy), .done(done), .err(err)
    );

    // Memory returns the word at the presented address L edges later.
    assign memRdata = pipe[L-1];
    always @(posedge clock) begin
      pipe[0] <= physMem[memAddr[7:2]];
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
      if (pokeEn) physMem[pokeIdx] <= pokeVal;
      else if (memWr) physMem[memAddr[7:2]] <= memWdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
        bad++;
        $display("[TB] FAIL cfg%0d %s: got %h want %h", g, name, act, exp);
      end
    endtask

    function automatic logic [31:0] extend(input logic [31:0] v, input int bits);
      if (S && v[bits-1]) return v | (32'hFFFF_FFFF << bits);
      return v;
    endfunction

    // Model: an accepted request at edge T finishes with done at T+D; k counts cycles since T.
    initial begin
      int sh;
      logic [31:0] word;
      mActive  = 1'b0;
      mMemAddr = 32'd0;
      mRdata   = 32'd0;
      @(posedge clock);
      forever begin
        @(negedge clock);
        if (mActive) begin
          if (mLoad && mK == mD) mRdata = mLoadVal;
          checkOutput("busy", 32'(busy), 32'd1);
          checkOutput("done", 32'(done), 32'(mK == mD));
          checkOutput("err", 32'(err), 32'(mErr && mK == mD));
          checkOutput("mem_wr", 32'(memWr), 32'(mStore && mK == mD - 1));
          if (mStore && mK == mD - 1) begin
            checkOutput("mem_wdata", memWdata, mWrVal);
            refMem[mIdx] = mWrVal;
          end
        end else begin
          checkOutput("busy", 32'(busy), 32'd0);
          checkOutput("done", 32'(done), 32'd0);
          checkOutput("err", 32'(err), 32'd0);
          checkOutput("mem_wr", 32'(memWr), 32'd0);
        end
        checkOutput("mem_addr", memAddr, mMemAddr);
        checkOutput("rdata", rdata, mRdata);
        if (pokeEn) refMem[pokeIdx] = pokeVal;
        if (!reset) begin
          mActive  = 1'b0;
          mMemAddr = 32'd0;
          mRdata   = 32'd0;
        end else if (mActive) begin
          mK++;
          if (mK > mD) mActive = 1'b0;
        end else if (start) begin
          mActive  = 1'b1;
          mK       = 1;
          mIdx     = addr[7:2];
          mMemAddr = {addr[31:2], 2'b00};
          word     = refMem[mIdx];
          mErr     = (op[1:0] == 2'b11) || (op[1:0] == 2'b00 && addr[1:0] != 2'b00)
                     || (op[1:0] == 2'b01 && addr[0]);
          mLoad    = !mErr && !op[2];
          mStore   = !mErr && op[2];
          mD       = mErr ? 1 : (op == 3'b100) ? 2 : mLoad ? L + 2 : L + 3;
          mLoadVal = word;
          mWrVal   = wdata;
          if (op[1:0] == 2'b01) begin
            sh       = 16 * int'(addr[1]);
            mLoadVal = extend((word >> sh) & 32'hFFFF, 16);
            mWrVal   = (word & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
          end else if (op[1:0] == 2'b10) begin
            sh       = 8 * int'(addr[1:0]);
            mLoadVal = extend((word >> sh) & 32'hFF, 8);
            mWrVal   = (word & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
          end
        end
      end
    end

    task automatic poke(input logic [5:0] idx, input logic [31:0] val);
      pokeEn  = 1'b1;
      pokeIdx = idx;
      pokeVal = val;
      @(posedge clock); #1;
      pokeEn  = 1'b0;
    endtask

    // Issues one request and waits (bounded) for done; n is the cycle count from the start edge.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                                 input bit noise, output int n, output bit sawErr);
      bit found;
      start = 1'b1; op = o; addr = a; wdata = w;
      @(posedge clock); #1;
      start = 1'b0; n = 0; sawErr = 1'b0; found = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        if (noise) begin
          start = ($urandom_range(0, 2) == 0);
          op    = 3'($urandom);
          addr  = $urandom;
          wdata = $urandom;
        end
        @(negedge clock);
        if (done) begin
          n = c; sawErr = err; found = 1'b1;
          break;
        end
        @(posedge clock); #1;
      end
      if (!found) begin
        total++; bad++;
        $display("[TB] FAIL cfg%0d done timeout: got none want pulse", g);
      end else begin
        @(posedge clock); #1;
      end
      start = 1'b0;
    endtask

    initial begin
      int n, dcnt, dlast;
      bit e;
      logic [2:0]  o;
      logic [31:0] a;
      reset = 1'b0; start = 1'b0; op = 3'd0; addr = 32'd0; wdata = 32'd0;
      pokeEn = 1'b0; pokeIdx = 6'd0; pokeVal = 32'd0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst mem_wdata", memWdata, 32'd0);
      checkOutput("rst rdata", rdata, 32'd0);
      for (int i = 0; i < 64; i++) poke(6'(i), $urandom);
      reset = 1'b1;
      @(posedge clock); #1;

      poke(6'h10, 32'h1122_3344);
      applyStimulus(3'b010, 32'h42, 32'd0, 1'b0, n, e);
      checkOutput("LB 0x42 rdata", rdata, 32'h0000_0022);
      checkOutput("LB latency", n, L + 2);
      applyStimulus(3'b001, 32'h42, 32'd0, 1'b0, n, e);
      checkOutput("LH 0x42 rdata", rdata, 32'h0000_1122);

      poke(6'h20, 32'hAABB_CCDD);
      applyStimulus(3'b110, 32'h81, 32'h0000_00EE, 1'b0, n, e);
      checkOutput("SB latency", n, L + 3);
      checkOutput("SB merged word", memWdata, 32'hAABB_EEDD);
      applyStimulus(3'b000, 32'h80, 32'd0, 1'b0, n, e);
      checkOutput("LW after SB", rdata, 32'hAABB_EEDD);

      applyStimulus(3'b100, 32'h10, 32'hDEAD_BEEF, 1'b0, n, e);
      checkOutput("SW latency", n, 2);
      checkOutput("SW keeps rdata", rdata, 32'hAABB_EEDD);
      applyStimulus(3'b000, 32'h12, 32'd0, 1'b0, n, e);
      checkOutput("LW misaligned err", 32'(e), 32'd1);
      checkOutput("err latency", n, 1);
      applyStimulus(3'b011, 32'h40, 32'd0, 1'b0, n, e);
      checkOutput("illegal op err", 32'(e), 32'd1);
      checkOutput("err keeps rdata", rdata, 32'hAABB_EEDD);

      poke(6'h08, 32'h0000_80F0);
      applyStimulus(3'b010, 32'h20, 32'd0, 1'b0, n, e);
      checkOutput("LB 0x20 ext", rdata, S ? 32'hFFFF_FFF0 : 32'h0000_00F0);
      applyStimulus(3'b001, 32'h20, 32'd0, 1'b0, n, e);
      checkOutput("LH 0x20 ext", rdata, S ? 32'hFFFF_80F0 : 32'h0000_80F0);

      start = 1'b1; op = 3'b101; addr = 32'h22; wdata = 32'h0000_5555;
      @(posedge clock); #1;
      start = 1'b0; reset = 1'b0;
      @(posedge clock); #1;
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort mem_addr", memAddr, 32'd0);
      checkOutput("abort mem_wdata", memWdata, 32'd0);
      checkOutput("abort rdata", rdata, 32'd0);
      reset = 1'b1;
      applyStimulus(3'b000, 32'h20, 32'd0, 1'b0, n, e);
      checkOutput("LW after abort", rdata, 32'h0000_80F0);

      dcnt = 0; dlast = -1;
      start = 1'b1; op = 3'b000; addr = 32'h80;
      for (int c = 0; c < 2 * L + 9; c++) begin
        if (c == L + 4) start = 1'b0;
        @(negedge clock);
        if (done) begin dcnt++; dlast = c; end
        @(posedge clock); #1;
      end
      checkOutput("held start done count", dcnt, 2);
      checkOutput("held start 2nd done", dlast, 2 * L + 5);

      for (int it = 0; it < 300; it++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
        o = 3'($urandom_range(0, 5));
        if (o >= 3'd3) o = o + 3'd1;
        if ($urandom_range(0, 11) == 0) o = {1'($urandom), 2'b11};
        a = $urandom;
        if (o[1:0] == 2'b00 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        if (o[1:0] == 2'b01 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
        if ($urandom_range(0, 24) == 0) begin
          start = 1'b1; op = o; addr = a; wdata = $urandom;
          @(posedge clock); #1;
          start = 1'b0;
          repeat ($urandom_range(0, L + 1)) begin @(posedge clock); #1; end
          reset = 1'b0;
          @(posedge clock); #1;
          reset = 1'b1;
        end else begin
          applyStimulus(o, a, $urandom, 1'($urandom), n, e);
        end
      end
      finishedCfg[g] = 1'b1;
    end
  end

  initial begin
    bit allDone;
    allDone = 1'b0;
    for (int c = 0; c < 20000 && !allDone; c++) begin
      @(posedge clock);
      allDone = finishedCfg[0] && finishedCfg[1];
    end
    if (!allDone) begin
      total++; bad++;
      $display("[TB] FAIL overall timeout: got unfinished want finished");
    end
    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
